// File: rtl/intersection_controller.sv
// Two-direction intersection sequencer: NS/EW lamp heads with all-red clearance,
// plus latched pedestrian requests served with a timed Walk at green start.
module intersection_controller #(
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 7,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int CNT_W    = 6
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic       Ped_req_ns,
  input  logic       Ped_req_ew,
  output logic       Ns_red,
  output logic       Ns_yellow,
  output logic       Ns_green,
  output logic       Ew_red,
  output logic       Ew_yellow,
  output logic       Ew_green,
  output logic       Walk_ns,
  output logic       Walk_ew,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    CLR_NS    = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    CLR_EW    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LIM    = CNT_W'(WALK_T);

  state_t           state_q;
  state_t           state_d;
  state_t           seq_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dur_last;
  logic             legal;
  logic             pend_ns_q;
  logic             pend_ew_q;
  logic             walk_act_ns_q;
  logic             walk_act_ew_q;
  logic             enter_ns;
  logic             enter_ew;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= CLR_EW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dur_last = ALLRED_LAST;
    seq_next = CLR_EW;
    legal    = 1'b1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      NS_GREEN: begin
        dur_last = GREEN_LAST;
        seq_next = NS_YELLOW;
      end
      NS_YELLOW: begin
        dur_last = YELLOW_LAST;
        seq_next = CLR_NS;
      end
      CLR_NS: begin
        dur_last = ALLRED_LAST;
        seq_next = EW_GREEN;
      end
      EW_GREEN: begin
        dur_last = GREEN_LAST;
        seq_next = EW_YELLOW;
      end
      EW_YELLOW: begin
        dur_last = YELLOW_LAST;
        seq_next = CLR_EW;
      end
      CLR_EW: begin
        dur_last = ALLRED_LAST;
        seq_next = NS_GREEN;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    // Illegal codes recover into clearance without waiting for a tick.
    if (!legal) begin
      state_d = CLR_EW;
      cnt_d   = '0;
    end else if (Enable) begin
      if (cnt_q == dur_last) begin
        state_d = seq_next;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign enter_ns = (state_q == CLR_EW) && (state_d == NS_GREEN);
  assign enter_ew = (state_q == CLR_NS) && (state_d == EW_GREEN);

  // A request landing on the serve edge is consumed by that serve.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_ns_q     <= 1'b0;
      pend_ew_q     <= 1'b0;
      walk_act_ns_q <= 1'b0;
      walk_act_ew_q <= 1'b0;
    end else begin
      if (enter_ns) begin
        walk_act_ns_q <= pend_ns_q | Ped_req_ns;
        pend_ns_q     <= 1'b0;
      end else begin
        walk_act_ns_q <= walk_act_ns_q && (state_d == NS_GREEN);
        if (Ped_req_ns) pend_ns_q <= 1'b1;
      end
      if (enter_ew) begin
        walk_act_ew_q <= pend_ew_q | Ped_req_ew;
        pend_ew_q     <= 1'b0;
      end else begin
        walk_act_ew_q <= walk_act_ew_q && (state_d == EW_GREEN);
        if (Ped_req_ew) pend_ew_q <= 1'b1;
      end
    end
  end

  assign Ns_green  = (state_q == NS_GREEN);
  assign Ns_yellow = (state_q == NS_YELLOW);
  assign Ns_red    = !(Ns_green || Ns_yellow);
  assign Ew_green  = (state_q == EW_GREEN);
  assign Ew_yellow = (state_q == EW_YELLOW);
  assign Ew_red    = !(Ew_green || Ew_yellow);

  assign Walk_ns = Ns_green && walk_act_ns_q && (cnt_q < WALK_LIM);
  assign Walk_ew = Ew_green && walk_act_ew_q && (cnt_q < WALK_LIM);

  assign Phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller: a cycle-position model pushes
// expected lamp/walk/phase words per stimulus cycle, compared after each edge.
module tb_intersection_controller;

  localparam int G   = 20;
  localparam int Y   = 7;
  localparam int A   = 2;
  localparam int W   = 10;
  localparam int EWS = G + Y + A;
  localparam int CYC = 2 * EWS;
  localparam logic [10:0] RST_OUT = 11'b100_100_00_101;

  logic       Clock;
  logic       Reset_n;
  logic       Enable;
  logic       Ped_req_ns;
  logic       Ped_req_ew;
  logic       Ns_red, Ns_yellow, Ns_green;
  logic       Ew_red, Ew_yellow, Ew_green;
  logic       Walk_ns, Walk_ew;
  logic [2:0] Phase;

  int n_chk  = 0;
  int n_pass = 0;

  logic [10:0] sb_q[$];

  int m_pos;
  bit m_pend_ns, m_pend_ew, m_act_ns, m_act_ew;

  intersection_controller dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .Ped_req_ns(Ped_req_ns),
    .Ped_req_ew(Ped_req_ew),
    .Ns_red    (Ns_red),
    .Ns_yellow (Ns_yellow),
    .Ns_green  (Ns_green),
    .Ew_red    (Ew_red),
    .Ew_yellow (Ew_yellow),
    .Ew_green  (Ew_green),
    .Walk_ns   (Walk_ns),
    .Walk_ew   (Walk_ew),
    .Phase     (Phase)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [10:0] obs();
    return {Ns_red, Ns_yellow, Ns_green, Ew_red, Ew_yellow, Ew_green, Walk_ns, Walk_ew, Phase};
  endfunction

  function automatic logic [10:0] model_out();
    logic [2:0] ph, ns, ew;
    logic wn, we;
    if (m_pos < G)               ph = 3'd0;
    else if (m_pos < G + Y)      ph = 3'd1;
    else if (m_pos < EWS)        ph = 3'd2;
    else if (m_pos < EWS + G)    ph = 3'd3;
    else if (m_pos < EWS + G + Y) ph = 3'd4;
    else                         ph = 3'd5;
    ns = (ph == 3'd0) ? 3'b001 : (ph == 3'd1) ? 3'b010 : 3'b100;
    ew = (ph == 3'd3) ? 3'b001 : (ph == 3'd4) ? 3'b010 : 3'b100;
    wn = m_act_ns && (m_pos < W);
    we = m_act_ew && (m_pos >= EWS) && (m_pos < EWS + W);
    return {ns, ew, wn, we, ph};
  endfunction

  task automatic model_reset();
    m_pos = CYC - A;
    m_pend_ns = 0; m_pend_ew = 0; m_act_ns = 0; m_act_ew = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, advance the model, queue its prediction, clock.
  task automatic step(input bit en, input bit rn, input bit re);
    bit ent_ns, ent_ew, lv_ns, lv_ew;
    Enable = en; Ped_req_ns = rn; Ped_req_ew = re;
    ent_ns = en && (m_pos == CYC - 1);
    ent_ew = en && (m_pos == EWS - 1);
    lv_ns  = en && (m_pos == G - 1);
    lv_ew  = en && (m_pos == EWS + G - 1);
    if (ent_ns) begin m_act_ns = m_pend_ns | rn; m_pend_ns = 0; end
    else begin if (lv_ns) m_act_ns = 0; if (rn) m_pend_ns = 1; end
    if (ent_ew) begin m_act_ew = m_pend_ew | re; m_pend_ew = 0; end
    else begin if (lv_ew) m_act_ew = 0; if (re) m_pend_ew = 1; end
    if (en) m_pos = (m_pos + 1) % CYC;
    sb_q.push_back(model_out());
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    #1 Reset_n = 1'b0;
    #2 got = obs();
    n_chk++;
    if (got !== RST_OUT) $display("FAIL reset_assert got=%b exp=%b", got, RST_OUT); else n_pass++;
    Enable = 1'b1;
    repeat (2) @(posedge Clock);
    #1 got = obs();
    n_chk++;
    if (got !== RST_OUT) $display("FAIL reset_hold got=%b exp=%b", got, RST_OUT); else n_pass++;
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sequence();
    logic [10:0] exp, got;
    int ng = 0, eg = 0, ph5 = 0;
    for (int i = 0; i < CYC + 1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL seq cyc=%0d got=%b exp=%b", i, got, exp); else n_pass++;
      if (i < 2 && Phase == 3'd5) ph5++;
      ng += int'(Ns_green); eg += int'(Ew_green);
    end
    n_chk++;
    if (ph5 != 1) $display("FAIL seq_initial_clr got=%0d exp=1", ph5); else n_pass++;
    n_chk++;
    if (ng != G) $display("FAIL seq_ns_green_len got=%0d exp=%0d", ng, G); else n_pass++;
    n_chk++;
    if (eg != G) $display("FAIL seq_ew_green_len got=%0d exp=%0d", eg, G); else n_pass++;
    step(1'b1, 1'b0, 1'b0);
    exp = sb_q.pop_front();
    n_chk++;
    if (Phase !== 3'd0 || obs() !== exp) $display("FAIL seq_wrap phase=%0d exp=0", Phase); else n_pass++;
  endtask

  task automatic test_ped_ew_pulse();
    logic [10:0] exp, got;
    int wn = 0, we = 0, cyc = 0;
    bit sent = 0, done = 0, re;
    while (!done && cyc < 200) begin
      re = !sent && (m_pos == 5);
      if (re) sent = 1;
      step(1'b1, 1'b0, re);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL ped_ew cyc=%0d got=%b exp=%b", cyc, got, exp); else n_pass++;
      wn += int'(Walk_ns); we += int'(Walk_ew); cyc++;
      done = sent && (m_pos == CYC - 1);
    end
    n_chk++;
    if (!done) $display("FAIL ped_ew_timeout got=%0d cycles exp=done", cyc); else n_pass++;
    n_chk++;
    if (we != W) $display("FAIL ped_ew_walk_len got=%0d exp=%0d", we, W); else n_pass++;
    n_chk++;
    if (wn != 0) $display("FAIL ped_ew_no_walk_ns got=%0d exp=0", wn); else n_pass++;
  endtask

  task automatic test_ped_ns_hold();
    logic [10:0] exp, got;
    int wa = 0, wb = 0, cyc = 0;
    bit pulsed = 0, wrap = 0, done = 0, rn;
    while (!done && cyc < 300) begin
      rn = (cyc == 0) || (!pulsed && cyc > 0 && m_pos == 15);
      if (cyc > 0 && rn) pulsed = 1;
      step(1'b1, rn, 1'b0);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL ped_ns cyc=%0d got=%b exp=%b", cyc, got, exp); else n_pass++;
      if (!wrap) wa += int'(Walk_ns); else wb += int'(Walk_ns);
      if (pulsed && m_pos == CYC - 1) wrap = 1;
      cyc++;
      done = wrap && (m_pos == G);
    end
    n_chk++;
    if (!done) $display("FAIL ped_ns_timeout got=%0d cycles exp=done", cyc); else n_pass++;
    n_chk++;
    if (wa != W) $display("FAIL ped_ns_first_walk got=%0d exp=%0d", wa, W); else n_pass++;
    n_chk++;
    if (wb != W) $display("FAIL ped_ns_deferred_walk got=%0d exp=%0d", wb, W); else n_pass++;
  endtask

  task automatic test_enable_div3();
    logic [10:0] exp, got;
    int ng = 0, wn = 0, we = 0;
    for (int k = 0; k < 3 * CYC; k++) begin
      step((k % 3) == 0, k == 2, k == 1);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL div3 cyc=%0d got=%b exp=%b", k, got, exp); else n_pass++;
      ng += int'(Ns_green); wn += int'(Walk_ns); we += int'(Walk_ew);
    end
    n_chk++;
    if (ng != 3 * G) $display("FAIL div3_ns_green_len got=%0d exp=%0d", ng, 3 * G); else n_pass++;
    n_chk++;
    if (we != 3 * W) $display("FAIL div3_walk_ew got=%0d exp=%0d", we, 3 * W); else n_pass++;
    n_chk++;
    if (wn != 3 * W) $display("FAIL div3_walk_ns got=%0d exp=%0d", wn, 3 * W); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp, got;
    int wn = 0, cyc = 0;
    bit sent = 0, rn;
    while (!sent && cyc < 200) begin
      rn = (m_pos == EWS + G + 1);
      if (rn) sent = 1;
      step(1'b1, rn, 1'b0);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", cyc, got, exp); else n_pass++;
      cyc++;
    end
    Ped_req_ns = 1'b0;
    Reset_n = 1'b0;
    #1 got = obs();
    n_chk++;
    if (got !== RST_OUT) $display("FAIL rst_mid_immediate got=%b exp=%b", got, RST_OUT); else n_pass++;
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    model_reset();
    cyc = 0;
    while (m_pos != G && cyc < 200) begin
      step(1'b1, 1'b0, 1'b0);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", cyc, got, exp); else n_pass++;
      wn += int'(Walk_ns); cyc++;
    end
    n_chk++;
    if (wn != 0) $display("FAIL rst_mid_pend_discard got=%0d exp=0", wn); else n_pass++;
  endtask

  task automatic test_both_clr_ns();
    logic [10:0] exp, got;
    int wn = 0, we = 0, cyc = 0;
    bit sent = 0, done = 0, r;
    while (!done && cyc < 300) begin
      r = !sent && (m_pos == G + Y);
      if (r) sent = 1;
      step(1'b1, r, r);
      exp = sb_q.pop_front(); got = obs();
      n_chk++;
      if (got !== exp) $display("FAIL both cyc=%0d got=%b exp=%b", cyc, got, exp); else n_pass++;
      wn += int'(Walk_ns); we += int'(Walk_ew); cyc++;
      done = sent && (m_pos == G);
    end
    n_chk++;
    if (!done) $display("FAIL both_timeout got=%0d cycles exp=done", cyc); else n_pass++;
    n_chk++;
    if (we != W) $display("FAIL both_walk_ew got=%0d exp=%0d", we, W); else n_pass++;
    n_chk++;
    if (wn != W) $display("FAIL both_walk_ns got=%0d exp=%0d", wn, W); else n_pass++;
  endtask

  initial begin
    Reset_n    = 1'b1;
    Enable     = 1'b0;
    Ped_req_ns = 1'b0;
    Ped_req_ew = 1'b0;
    model_reset();
    test_reset();
    test_sequence();
    test_ped_ew_pulse();
    test_ped_ns_hold();
    test_enable_div3();
    test_reset_mid();
    test_both_clr_ns();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences a two-direction intersection: North-South (NS) and East-West (EW) signal heads, each with Red/Yellow/Green lamps.
- Inserts an all-red clearance interval between the two directions.
- Latches pedestrian crossing requests and grants a timed Walk signal at the start of the matching direction's green.
- Top-level timing sequencer for the lamp drivers; one Enable-qualified cycle is one time tick.

Parameters:
GREEN_T, 20, green duration in enabled cycles (>=1)
YELLOW_T, 7, yellow duration in enabled cycles (>=1)
ALLRED_T, 2, all-red clearance duration in enabled cycles (>=1)
WALK_T, 10, Walk duration in enabled cycles; 1 <= WALK_T <= GREEN_T
CNT_W, 6, phase counter width; every duration must be <= 2^CNT_W

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
Enable  in  1  tick qualifier; state and counter advance only when high
Ped_req_ns  in  1  pedestrian request to cross parallel to NS traffic; level or pulse, sampled each clock
Ped_req_ew  in  1  pedestrian request to cross parallel to EW traffic
Ns_red  out  1  NS red lamp
Ns_yellow  out  1  NS yellow lamp
Ns_green  out  1  NS green lamp
Ew_red  out  1  EW red lamp
Ew_yellow  out  1  EW yellow lamp
Ew_green  out  1  EW green lamp
Walk_ns  out  1  NS pedestrian Walk
Walk_ew  out  1  EW pedestrian Walk
Phase  out  3  current state code, for debug and status

Behaviour:
- Reset (async, Reset_n low):
  - State = CLR_EW (code 5); counter = 0.
  - Pending flags and walk-active flags = 0.
  - Outputs during reset: both heads red, Walk_* = 0, Phase = 5.
- FSM codes:
  - NS_GREEN = 0, NS_YELLOW = 1, CLR_NS = 2, EW_GREEN = 3, EW_YELLOW = 4, CLR_EW = 5.
  - Codes 6 and 7 are illegal. On the next edge, regardless of Enable, go to CLR_EW with counter = 0.
- Sequence: NS_GREEN -> NS_YELLOW -> CLR_NS -> EW_GREEN -> EW_YELLOW -> CLR_EW -> NS_GREEN.
- State durations: GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T.
- Counter:
  - On an edge with Enable=1: if counter == dur-1, advance state and set counter to 0; otherwise increment counter.
  - On an edge with Enable=0: state and counter hold.
  - Full cycle = 2*(GREEN_T+YELLOW_T+ALLRED_T) enabled cycles (58 with defaults).
- Lamps (Moore, decoded from registered state only):
  - Ns_green = NS_GREEN; Ns_yellow = NS_YELLOW; Ns_red in all other states.
  - EW lamps decode symmetrically from EW_GREEN / EW_YELLOW.
  - Exactly one lamp per head is on at all times.
  - Never green or yellow on both heads simultaneously.
- Pedestrian requests (NS shown; EW is symmetric):
  - pend_ns is set on any edge where Ped_req_ns = 1. It is set regardless of Enable.
  - Serve: on the edge entering NS_GREEN (CLR_EW -> NS_GREEN), if pend_ns = 1 or Ped_req_ns = 1 on that edge, set walk_act_ns = 1 and clear pend_ns.
  - A request on the same edge as the serve is consumed and does not re-set pend_ns.
  - Walk_ns = (state == NS_GREEN) && walk_act_ns && (counter < WALK_T). Walk_ns is therefore high for exactly WALK_T enabled cycles from green start, and is stretched while Enable = 0.
  - walk_act_ns clears on the edge leaving NS_GREEN.
  - A request arriving during NS_GREEN after the entry edge stays pending and is served at the next NS_GREEN. The current green is not extended or restarted.
  - A request never alters phase timing.
- Simultaneous Ped_req_ns and Ped_req_ew: both are latched independently and each is served at its own green.
- Reset mid-operation: immediate return to the reset values above; pending requests are discarded.
- Width rule: counter compares are done at CNT_W bits. Durations are cast to CNT_W; parameter legality is the integrator's responsibility.

Test Plan:
- Reset release, Enable = 1 constantly:
  - Phase = 5 and all red for 2 cycles.
  - Ns_green rises after the 2nd enabled edge and holds 20 cycles; then Ns_yellow for 7; CLR_NS all red for 2; Ew_green for 20.
  - Phase returns to 0 at 58 cycles.
- Ped_req_ew single-cycle pulse during NS_GREEN counter = 5 -> Walk_ew high for exactly the first 10 cycles of the next EW_GREEN; Walk_ns stays 0.
- Ped_req_ns held high through the CLR_EW -> NS_GREEN entry edge and then dropped -> Walk_ns for 10 cycles.
  - Then a second Ped_req_ns pulse at NS_GREEN counter = 15 -> no Walk in the current green; Walk_ns for 10 cycles at the following NS_GREEN.
- Enable toggled 1-of-3 cycles -> durations scale by 3 (NS green spans 60 clocks); Ped_req pulses while Enable = 0 are still latched and served.
- Reset_n pulsed low mid EW_YELLOW with pend_ns = 1 -> outputs are all red immediately and Phase = 5; no Walk_ns at the next NS_GREEN.
- Both Ped_req lines pulsed in the same cycle during CLR_NS -> Walk_ew at the upcoming EW_GREEN and Walk_ns at the following NS_GREEN, each 10 cycles.
